// File: rtl/sht_scan_scheduler.sv
// Measurement scheduler for four SHT-style sensors. It starts one channel at a time and
// times out silent channels. It keeps the last good temperature/humidity result of each channel.
module sht_scan_scheduler #(
    parameter int          NCH         = 4,
    parameter logic [23:0] TIMEOUT_CYC = 24'd12000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [15:0]       PERIOD,
    input  logic [NCH-1:0]    CH_MASK,
    input  logic [NCH-1:0]    DONE,
    input  logic [16*NCH-1:0] TEMP_IN,
    input  logic [16*NCH-1:0] HUMID_IN,
    input  logic [1:0]        RD_CH,
    output logic [NCH-1:0]    START,
    output logic [15:0]       RD_TEMP,
    output logic [15:0]       RD_HUMID,
    output logic [NCH-1:0]    VALID,
    output logic [NCH-1:0]    TERR,
    output logic [1:0]        CUR_CH,
    output logic              IDLE
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GAP   = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_STORE = 3'd5;

    logic [2:0]     state;
    logic [NCH-1:0] scan_mask;
    logic [23:0]    tcnt;
    logic [15:0]    gap_cnt;
    logic           store_ok;
    logic           abort;
    logic [15:0]    temp_q  [NCH];
    logic [15:0]    humid_q [NCH];

    logic           first_hit;
    logic [1:0]     first_idx;
    logic           next_hit;
    logic [1:0]     next_idx;
    logic           done_sel;
    logic           timed_out;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        first_hit = 1'b0;
        first_idx = 2'd0;
        next_hit  = 1'b0;
        next_idx  = 2'd0;
        // A descending sweep leaves the lowest qualifying channel as the winner.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (CH_MASK[i]) begin
                first_hit = 1'b1;
                first_idx = 2'(i);
            end
            if (scan_mask[i] && (i > int'(CUR_CH))) begin
                next_hit = 1'b1;
                next_idx = 2'(i);
            end
        end
    end

    assign done_sel  = DONE[CUR_CH];
    assign timed_out = (tcnt >= (TIMEOUT_CYC - 24'd1));

    always_comb begin
        START = '0;
        if (state == S_START)
            START[CUR_CH] = 1'b1;
    end

    assign IDLE     = (state == S_IDLE);
    assign RD_TEMP  = temp_q[RD_CH];
    assign RD_HUMID = humid_q[RD_CH];

    // NOTE: sequential state uses non-blocking assignments only, so each register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            scan_mask <= '0;
            tcnt      <= '0;
            gap_cnt   <= '0;
            store_ok  <= 1'b0;
            abort     <= 1'b0;
            VALID     <= '0;
            TERR      <= '0;
            CUR_CH    <= 2'd0;
            // NOTE: the result file is reset on purpose because software may read it before any scan completes.
            for (int i = 0; i < NCH; i++) begin
                temp_q[i]  <= '0;
                humid_q[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (EN)
                        state <= S_SCAN;
                end

                S_SCAN: begin
                    scan_mask <= CH_MASK;
                    abort     <= 1'b0;
                    if (first_hit) begin
                        CUR_CH <= first_idx;
                        state  <= S_START;
                    end else begin
                        CUR_CH  <= 2'd0;
                        gap_cnt <= PERIOD;
                        state   <= S_GAP;
                    end
                end

                S_START: begin
                    tcnt <= '0;
                    if (!EN)
                        abort <= 1'b1;
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (!EN)
                        abort <= 1'b1;
                    if (tcnt != '1)
                        tcnt <= tcnt + 24'd1;
                    // A completion in the timeout cycle still counts as success.
                    if (done_sel) begin
                        store_ok <= 1'b1;
                        state    <= S_STORE;
                    end else if (timed_out) begin
                        store_ok <= 1'b0;
                        state    <= S_STORE;
                    end
                end

                S_STORE: begin
                    if (store_ok) begin
                        temp_q[CUR_CH]  <= TEMP_IN[{CUR_CH, 4'b0000} +: 16];
                        humid_q[CUR_CH] <= HUMID_IN[{CUR_CH, 4'b0000} +: 16];
                        VALID[CUR_CH]   <= 1'b1;
                        TERR[CUR_CH]    <= 1'b0;
                    end else begin
                        VALID[CUR_CH]   <= 1'b0;
                        TERR[CUR_CH]    <= 1'b1;
                    end
                    if (next_hit && EN && !abort) begin
                        CUR_CH <= next_idx;
                        state  <= S_START;
                    end else begin
                        gap_cnt <= PERIOD;
                        state   <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == 16'd0)
                        state <= EN ? S_SCAN : S_IDLE;
                    else
                        gap_cnt <= gap_cnt - 16'd1;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sht_scan_scheduler.sv
// Directed bench for sht_scan_scheduler: a sensor responder answers START pulses after a set latency,
// and each scenario task compares ports against hand-derived cycle counts and values.
module tb_sht_scan_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b0;
    logic [15:0] PERIOD = '0;
    logic [3:0]  CH_MASK = '0;
    logic [3:0]  DONE;
    logic [63:0] TEMP_IN = '0;
    logic [63:0] HUMID_IN = '0;
    logic [1:0]  RD_CH = '0;
    logic [3:0]  START;
    logic [15:0] RD_TEMP;
    logic [15:0] RD_HUMID;
    logic [3:0]  VALID;
    logic [3:0]  TERR;
    logic [1:0]  CUR_CH;
    logic        IDLE;

    logic [3:0]  resp_done = '0;
    logic [3:0]  stray_done = '0;
    int          resp_lat [4];
    int          resp_cd [4];
    int          n_cmp = 0;
    int          n_err = 0;

    assign DONE = resp_done | stray_done;

    sht_scan_scheduler #(.NCH(4), .TIMEOUT_CYC(24'd100)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .PERIOD(PERIOD), .CH_MASK(CH_MASK),
        .DONE(DONE), .TEMP_IN(TEMP_IN), .HUMID_IN(HUMID_IN), .RD_CH(RD_CH),
        .START(START), .RD_TEMP(RD_TEMP), .RD_HUMID(RD_HUMID), .VALID(VALID),
        .TERR(TERR), .CUR_CH(CUR_CH), .IDLE(IDLE)
    );

    always #5 CLK = ~CLK;

    // Sensor model: a START seen in cycle k produces a DONE in cycle k+lat. lat=0 means the sensor never answers.
    always @(negedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            resp_done[i] = 1'b0;
            if (START[i] && resp_lat[i] > 0)
                resp_cd[i] = resp_lat[i];
            else if (resp_cd[i] > 0) begin
                resp_cd[i] = resp_cd[i] - 1;
                if (resp_cd[i] == 0)
                    resp_done[i] = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wait_start(output logic [3:0] seen, output int n, input int budget);
        seen = '0;
        n    = 0;
        while (n < budget && seen == 4'b0000) begin
            tick();
            n++;
            seen = START;
        end
    endtask

    task automatic wait_idle(output int n, output bit ok, input int budget);
        ok = 1'b0;
        n  = 0;
        while (n < budget && !ok) begin
            tick();
            n++;
            ok = IDLE;
        end
    endtask

    task automatic set_data(input logic [15:0] t0, input logic [15:0] h0);
        for (int i = 0; i < 4; i++) begin
            TEMP_IN[16*i +: 16]  = t0 + 16'(i);
            HUMID_IN[16*i +: 16] = h0 + 16'(i);
        end
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        resp_lat[0] = l0;
        resp_lat[1] = l1;
        resp_lat[2] = l2;
        resp_lat[3] = l3;
    endtask

    task automatic rd(input logic [1:0] ch);
        RD_CH = ch;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (START !== 4'b0000 || VALID !== 4'b0000 || TERR !== 4'b0000 || CUR_CH !== 2'd0 || IDLE !== 1'b1) begin
            n_err++;
            $display("FAIL reset_outputs: start=%b valid=%b terr=%b cur=%0d idle=%b, want 0000 0000 0000 0 1",
                     START, VALID, TERR, CUR_CH, IDLE);
        end
        for (int ch = 0; ch < 4; ch++) begin
            rd(2'(ch));
            n_cmp++;
            if (RD_TEMP !== 16'h0000 || RD_HUMID !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_results ch%0d: temp=%h humid=%h, want 0000 0000", ch, RD_TEMP, RD_HUMID);
            end
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_full_scan();
        logic [3:0] seen;
        logic [3:0] exp_s;
        int n;
        bit ok;
        PERIOD = 16'd10;
        CH_MASK = 4'b1111;
        set_lat(50, 50, 50, 50);
        set_data(16'h0100, 16'h0200);
        EN = 1'b1;
        wait_start(seen, n, 10);
        n_cmp++;
        if (seen !== 4'b0001 || n != 2 || CUR_CH !== 2'd0) begin
            n_err++;
            $display("FAIL full_first_start: start=%b after %0d cycles cur=%0d, want 0001 after 2 cur=0", seen, n, CUR_CH);
        end
        // One START, 50 cycles in WAIT, and one STORE give 52 cycles between consecutive STARTs.
        for (int ch = 1; ch < 4; ch++) begin
            exp_s = 4'b0001 << ch;
            wait_start(seen, n, 200);
            n_cmp++;
            if (seen !== exp_s || n != 52 || CUR_CH !== 2'(ch)) begin
                n_err++;
                $display("FAIL full_start_ch%0d: start=%b after %0d cycles cur=%0d, want %b after 52", ch, seen, n, CUR_CH, exp_s);
            end
        end
        // From START[3] to the next START[0]: 52 cycles of ch3, 11 GAP cycles (10..0), and 1 SCAN cycle.
        wait_start(seen, n, 300);
        n_cmp++;
        if (seen !== 4'b0001 || n != 64) begin
            n_err++;
            $display("FAIL full_rescan: start=%b after %0d cycles, want 0001 after 64", seen, n);
        end
        n_cmp++;
        if (VALID !== 4'b1111 || TERR !== 4'b0000) begin
            n_err++;
            $display("FAIL full_flags: valid=%b terr=%b, want 1111 0000", VALID, TERR);
        end
        rd(2'd2);
        n_cmp++;
        if (RD_TEMP !== 16'h0102 || RD_HUMID !== 16'h0202) begin
            n_err++;
            $display("FAIL full_read_ch2: temp=%h humid=%h, want 0102 0202", RD_TEMP, RD_HUMID);
        end
        rd(2'd0);
        n_cmp++;
        if (RD_TEMP !== 16'h0100 || RD_HUMID !== 16'h0200) begin
            n_err++;
            $display("FAIL full_read_ch0: temp=%h humid=%h, want 0100 0200", RD_TEMP, RD_HUMID);
        end
        EN = 1'b0;
        wait_idle(n, ok, 300);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL full_stop: idle=%b after %0d cycles, want 1", IDLE, n);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] seen;
        int n;
        bit ok;
        PERIOD = 16'd10;
        CH_MASK = 4'b1010;
        set_lat(0, 50, 0, 0);
        set_data(16'h1100, 16'h1200);
        EN = 1'b1;
        wait_start(seen, n, 10);
        n_cmp++;
        if (seen !== 4'b0010 || n != 2) begin
            n_err++;
            $display("FAIL to_first_start: start=%b after %0d cycles, want 0010 after 2", seen, n);
        end
        wait_start(seen, n, 200);
        n_cmp++;
        if (seen !== 4'b1000 || n != 52) begin
            n_err++;
            $display("FAIL to_start_ch3: start=%b after %0d cycles, want 1000 after 52", seen, n);
        end
        // WAIT covers cycles k+1..k+100 and STORE is k+101, so flags must still be unchanged there.
        for (int i = 0; i < 101; i++)
            tick();
        n_cmp++;
        if (TERR !== 4'b0000 || VALID !== 4'b1111) begin
            n_err++;
            $display("FAIL to_before_store: terr=%b valid=%b, want 0000 1111", TERR, VALID);
        end
        tick();
        n_cmp++;
        if (TERR !== 4'b1000 || VALID !== 4'b0111) begin
            n_err++;
            $display("FAIL to_after_store: terr=%b valid=%b, want 1000 0111", TERR, VALID);
        end
        rd(2'd3);
        n_cmp++;
        if (RD_TEMP !== 16'h0103 || RD_HUMID !== 16'h0203) begin
            n_err++;
            $display("FAIL to_ch3_retained: temp=%h humid=%h, want 0103 0203", RD_TEMP, RD_HUMID);
        end
        rd(2'd1);
        n_cmp++;
        if (RD_TEMP !== 16'h1101 || RD_HUMID !== 16'h1201) begin
            n_err++;
            $display("FAIL to_ch1_new: temp=%h humid=%h, want 1101 1201", RD_TEMP, RD_HUMID);
        end
        EN = 1'b0;
        wait_idle(n, ok, 100);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL to_stop: idle=%b after %0d cycles, want 1", IDLE, n);
        end
    endtask

    task automatic test_done_priority();
        logic [3:0] seen;
        int n;
        bit ok;
        PERIOD = 16'd2;
        CH_MASK = 4'b0101;
        set_lat(20, 0, 0, 0);
        set_data(16'h2200, 16'h4400);
        EN = 1'b1;
        wait_start(seen, n, 10);
        n_cmp++;
        if (seen !== 4'b0001 || n != 2) begin
            n_err++;
            $display("FAIL pri_first_start: start=%b after %0d cycles, want 0001 after 2", seen, n);
        end
        wait_start(seen, n, 100);
        n_cmp++;
        if (seen !== 4'b0100 || n != 22) begin
            n_err++;
            $display("FAIL pri_start_ch2: start=%b after %0d cycles, want 0100 after 22", seen, n);
        end
        // A stray DONE[0] during ch2's wait would corrupt ch2 if it were honoured.
        for (int i = 0; i < 4; i++)
            tick();
        stray_done = 4'b0001;
        TEMP_IN[47:32] = 16'hBAD2;
        tick();
        stray_done = 4'b0000;
        tick();
        TEMP_IN[47:32] = 16'h2202;
        for (int i = 0; i < 94; i++)
            tick();
        rd(2'd2);
        n_cmp++;
        if (CUR_CH !== 2'd2 || RD_TEMP !== 16'h0102 || START !== 4'b0000) begin
            n_err++;
            $display("FAIL pri_still_waiting: cur=%0d temp=%h start=%b, want 2 0102 0000", CUR_CH, RD_TEMP, START);
        end
        // This is WAIT cycle k+100 (tcnt=99): DONE[2] arrives together with the timeout.
        stray_done = 4'b0100;
        tick();
        stray_done = 4'b0000;
        n_cmp++;
        if (RD_TEMP !== 16'h0102) begin
            n_err++;
            $display("FAIL pri_read_during_store: temp=%h, want 0102", RD_TEMP);
        end
        tick();
        n_cmp++;
        if (VALID !== 4'b0111 || TERR !== 4'b1000) begin
            n_err++;
            $display("FAIL pri_flags: valid=%b terr=%b, want 0111 1000", VALID, TERR);
        end
        n_cmp++;
        if (RD_TEMP !== 16'h2202 || RD_HUMID !== 16'h4402) begin
            n_err++;
            $display("FAIL pri_ch2_data: temp=%h humid=%h, want 2202 4402", RD_TEMP, RD_HUMID);
        end
        rd(2'd0);
        n_cmp++;
        if (RD_TEMP !== 16'h2200 || RD_HUMID !== 16'h4400) begin
            n_err++;
            $display("FAIL pri_ch0_data: temp=%h humid=%h, want 2200 4400", RD_TEMP, RD_HUMID);
        end
        EN = 1'b0;
        wait_idle(n, ok, 50);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL pri_stop: idle=%b after %0d cycles, want 1", IDLE, n);
        end
    endtask

    task automatic test_empty_mask();
        int starts;
        int idles;
        PERIOD = 16'd0;
        CH_MASK = 4'b0000;
        set_lat(0, 0, 0, 0);
        EN = 1'b1;
        starts = 0;
        idles  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (START !== 4'b0000)
                starts++;
            if (IDLE !== 1'b0)
                idles++;
        end
        n_cmp++;
        if (starts != 0 || idles != 0) begin
            n_err++;
            $display("FAIL empty_loop: start cycles=%0d idle cycles=%0d, want 0 0", starts, idles);
        end
        EN = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (IDLE !== 1'b1 || CUR_CH !== 2'd0) begin
            n_err++;
            $display("FAIL empty_stop: idle=%b cur=%0d, want 1 0", IDLE, CUR_CH);
        end
    endtask

    task automatic test_en_drop();
        logic [3:0] seen;
        int n;
        int starts;
        bit ok;
        PERIOD = 16'd5;
        CH_MASK = 4'b1111;
        set_lat(30, 30, 30, 30);
        set_data(16'h3300, 16'h5500);
        EN = 1'b1;
        wait_start(seen, n, 10);
        n_cmp++;
        if (seen !== 4'b0001 || n != 2) begin
            n_err++;
            $display("FAIL drop_first_start: start=%b after %0d cycles, want 0001 after 2", seen, n);
        end
        wait_start(seen, n, 100);
        n_cmp++;
        if (seen !== 4'b0010 || n != 32) begin
            n_err++;
            $display("FAIL drop_start_ch1: start=%b after %0d cycles, want 0010 after 32", seen, n);
        end
        for (int i = 0; i < 3; i++)
            tick();
        EN = 1'b0;
        // ch1 STORE at k+31, GAP k+32..k+37 (5..0), IDLE at k+38, which is 35 cycles after this point.
        starts = 0;
        ok = 1'b0;
        n = 0;
        while (n < 100 && !ok) begin
            tick();
            n++;
            if (START !== 4'b0000)
                starts++;
            ok = IDLE;
        end
        n_cmp++;
        if (!ok || n != 35 || starts != 0) begin
            n_err++;
            $display("FAIL drop_to_idle: idle=%b after %0d cycles starts=%0d, want 1 after 35 starts=0", IDLE, n, starts);
        end
        rd(2'd1);
        n_cmp++;
        if (RD_TEMP !== 16'h3301 || VALID !== 4'b0111 || TERR !== 4'b1000) begin
            n_err++;
            $display("FAIL drop_ch1_stored: temp=%h valid=%b terr=%b, want 3301 0111 1000", RD_TEMP, VALID, TERR);
        end
        rd(2'd2);
        n_cmp++;
        if (RD_TEMP !== 16'h2202) begin
            n_err++;
            $display("FAIL drop_ch2_skipped: temp=%h, want 2202", RD_TEMP);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [3:0] seen;
        int n;
        int bad;
        PERIOD = 16'd3;
        CH_MASK = 4'b0100;
        set_lat(0, 0, 20, 0);
        EN = 1'b1;
        wait_start(seen, n, 10);
        n_cmp++;
        if (seen !== 4'b0100 || n != 2 || CUR_CH !== 2'd2) begin
            n_err++;
            $display("FAIL rst_start_ch2: start=%b after %0d cycles cur=%0d, want 0100 after 2 cur=2", seen, n, CUR_CH);
        end
        for (int i = 0; i < 5; i++)
            tick();
        RST = 1'b1;
        tick();
        n_cmp++;
        if (START !== 4'b0000 || VALID !== 4'b0000 || TERR !== 4'b0000 || IDLE !== 1'b1 || CUR_CH !== 2'd0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: start=%b valid=%b terr=%b idle=%b cur=%0d, want 0000 0000 0000 1 0",
                     START, VALID, TERR, IDLE, CUR_CH);
        end
        rd(2'd1);
        n_cmp++;
        if (RD_TEMP !== 16'h0000 || RD_HUMID !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_mid_results: temp=%h humid=%h, want 0000 0000", RD_TEMP, RD_HUMID);
        end
        RST = 1'b0;
        EN = 1'b0;
        // The sensor's late DONE[2] arrives in this window and must leave the scheduler untouched.
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (IDLE !== 1'b1 || VALID !== 4'b0000 || TERR !== 4'b0000 || START !== 4'b0000)
                bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rst_late_done: %0d disturbed cycles, want 0 (idle=%b valid=%b)", bad, IDLE, VALID);
        end
    endtask

    initial begin
        set_lat(0, 0, 0, 0);
        test_reset();
        test_full_scan();
        test_timeout();
        test_done_priority();
        test_empty_mask();
        test_en_drop();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
